// File: rtl/instmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instmem_pkg
//  Description : Shared types and default constants for the MIPS16
//                instruction memory / fetch block. Contains no ports.
//  Revision    : 1.0  initial release
// ============================================================================
package instmem_pkg;

    // Default geometry of the original 24-word, 16-bit instruction store.
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DEPTH  = 24;

    // Wait-state counter width; wide enough for WAIT_STATES up to 15.
    localparam int WAIT_W = 4;

    // add $0,$0,$0 encodes as all zeros.
    localparam logic [15:0] DEF_NOP_WORD = 16'h0000;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage : instmem_pkg
`default_nettype wire

// File: rtl/instmem_if.sv
`default_nettype none
// ============================================================================
//  Module      : instmem_if
//  Description : Fetch request/response bus between the PC/fetch stage
//                (master) and the instruction memory (slave).
//                req_valid/req_ready/req_addr : fetch request handshake
//                rsp_valid/rsp_ready          : response handshake
//                rsp_inst/rsp_fault           : fetched word and range fault
//                flush                        : cancel outstanding fetch
//  Revision    : 1.0  initial release
// ============================================================================
interface instmem_if
    import instmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_inst;
    logic              rsp_fault;
    logic              flush;

    modport master (
        output req_valid, req_addr, rsp_ready, flush,
        input  req_ready, rsp_valid, rsp_inst, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, flush,
        output req_ready, rsp_valid, rsp_inst, rsp_fault
    );

endinterface : instmem_if
`default_nettype wire

// File: rtl/instmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : instmem_array
//  Description : DEPTH x DATA_W instruction storage.
//                One synchronous write port (out-of-range writes dropped),
//                one synchronous read port with read-before-write and an
//                address range check that returns NOP_WORD plus a fault.
//  Ports       : clk, rst       clock / synchronous reset of read outputs
//                i_rd_en        capture a read this edge
//                i_rd_addr      read word address
//                i_wr_en        write this edge
//                i_wr_addr      write word address
//                i_wr_data      write data
//                o_rd_data      registered read data
//                o_rd_fault     registered out-of-range flag
//  Revision    : 1.0  initial release
// ============================================================================
module instmem_array
    import instmem_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEF_NOP_WORD)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_rd_en,
    input  wire logic [ADDR_W-1:0] i_rd_addr,
    input  wire logic              i_wr_en,
    input  wire logic [ADDR_W-1:0] i_wr_addr,
    input  wire logic [DATA_W-1:0] i_wr_data,
    output logic      [DATA_W-1:0] o_rd_data,
    output logic                   o_rd_fault
);

    localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    // Storage comes up holding NOP_WORD everywhere; reset never touches it.
    logic [DATA_W-1:0] r_mem [DEPTH] = '{default: NOP_WORD};

    logic              w_rd_in_range;
    logic              w_wr_in_range;
    logic [DATA_W-1:0] w_rd_data_d;
    logic              w_rd_fault_d;
    logic [DATA_W-1:0] r_rd_data_q;
    logic              r_rd_fault_q;

    // Range checks use the full address width so aliasing high addresses
    // onto implemented words is impossible.
    assign w_rd_in_range = ({1'b0, i_rd_addr} < c_depth);
    assign w_wr_in_range = ({1'b0, i_wr_addr} < c_depth);

    always_comb begin
        w_rd_data_d  = r_rd_data_q;
        w_rd_fault_d = r_rd_fault_q;
        if (i_rd_en) begin
            if (w_rd_in_range) begin
                w_rd_data_d  = r_mem[i_rd_addr[c_idx_w-1:0]];
                w_rd_fault_d = 1'b0;
            end else begin
                w_rd_data_d  = NOP_WORD;
                w_rd_fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data_q  <= '0;
            r_rd_fault_q <= 1'b0;
        end else begin
            r_rd_data_q  <= w_rd_data_d;
            r_rd_fault_q <= w_rd_fault_d;
        end
    end

    // Non-blocking update: a read of the same word on this edge still sees
    // the previous contents.
    always_ff @(posedge clk) begin
        if (i_wr_en && w_wr_in_range) begin
            r_mem[i_wr_addr[c_idx_w-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data  = r_rd_data_q;
    assign o_rd_fault = r_rd_fault_q;

endmodule : instmem_array
`default_nettype wire

// File: rtl/instmem_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instmem_fetch
//  Description : MIPS16 instruction memory with valid/ready fetch handshake,
//                configurable wait states, out-of-range fault reporting,
//                pipeline-redirect flush and a run-time load port.
//  Ports       : clk, rst   clock / synchronous active-high reset
//                bus        instmem_if.slave fetch request/response bus
//                ld_en      write ld_data to ld_addr this cycle
//                ld_addr    load word address
//                ld_data    load word
//                busy       sequencer not idle
//  Revision    : 1.0  initial release
// ============================================================================
module instmem_fetch
    import instmem_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                DEPTH       = DEF_DEPTH,
    parameter int                WAIT_STATES = 0,
    parameter logic [DATA_W-1:0] NOP_WORD    = DATA_W'(DEF_NOP_WORD)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    instmem_if.slave               bus,
    input  wire logic              ld_en,
    input  wire logic [ADDR_W-1:0] ld_addr,
    input  wire logic [DATA_W-1:0] ld_data,
    output logic                   busy
);

    localparam logic [1:0] c_st_idle = S_IDLE;
    localparam logic [1:0] c_st_wait = S_WAIT;
    localparam logic [1:0] c_st_resp = S_RESP;

    logic [1:0]        r_state_q;
    logic [1:0]        w_state_d;
    logic [WAIT_W-1:0] r_cnt_q;
    logic [WAIT_W-1:0] w_cnt_d;
    logic [ADDR_W-1:0] r_addr_q;
    logic [ADDR_W-1:0] w_addr_d;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;

    // A new request can be taken when idle, or when the held response is
    // being consumed in the same cycle (back-to-back). Flush and loads
    // block acceptance so neither can collide with a fetch.
    assign w_req_ready = !rst && !bus.flush && !ld_en &&
                         ((r_state_q == c_st_idle) ||
                          ((r_state_q == c_st_resp) && bus.rsp_ready));
    assign w_accept    = bus.req_valid && w_req_ready;

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_addr_d  = r_addr_q;
        w_rd_en   = 1'b0;
        w_rd_addr = r_addr_q;

        if (bus.flush) begin
            // Drop whatever is outstanding; rsp_inst keeps its last value.
            w_state_d = c_st_idle;
            w_cnt_d   = '0;
        end else begin
            case (r_state_q)
                c_st_idle, c_st_resp: begin
                    if (w_accept) begin
                        w_addr_d = bus.req_addr;
                        if (WAIT_STATES == 0) begin
                            // Address is latched on this same edge, so the
                            // read must use the live request address.
                            w_state_d = c_st_resp;
                            w_rd_en   = 1'b1;
                            w_rd_addr = bus.req_addr;
                        end else begin
                            w_state_d = c_st_wait;
                            w_cnt_d   = WAIT_W'(WAIT_STATES);
                        end
                    end else if ((r_state_q == c_st_resp) && bus.rsp_ready) begin
                        w_state_d = c_st_idle;
                    end
                end
                c_st_wait: begin
                    // Last wait cycle: read with the latched address.
                    if (r_cnt_q <= WAIT_W'(1)) begin
                        w_state_d = c_st_resp;
                        w_cnt_d   = '0;
                        w_rd_en   = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt_q - WAIT_W'(1);
                    end
                end
                default: begin
                    w_state_d = c_st_idle;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_st_idle;
            r_cnt_q   <= '0;
            r_addr_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_addr_q  <= w_addr_d;
        end
    end

    instmem_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP_WORD)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_en    (w_rd_en),
        .i_rd_addr  (w_rd_addr),
        .i_wr_en    (ld_en),
        .i_wr_addr  (ld_addr),
        .i_wr_data  (ld_data),
        .o_rd_data  (bus.rsp_inst),
        .o_rd_fault (bus.rsp_fault)
    );

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = (r_state_q == c_st_resp);
    assign busy          = (r_state_q != c_st_idle);

endmodule : instmem_fetch
`default_nettype wire

// File: tb/tb_instmem_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instmem_fetch
//  Description : Directed self-checking bench. Three instances share the
//                clock, reset and load port: index 0 has WAIT_STATES=0,
//                index 1 has WAIT_STATES=2, index 2 has WAIT_STATES=3.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instmem_fetch;

    localparam int AW = 13;
    localparam int DW = 16;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;

    logic          req_valid   [NI];
    logic [AW-1:0] req_addr    [NI];
    logic          rsp_ready   [NI];
    logic          flush       [NI];
    logic          req_ready_o [NI];
    logic          rsp_valid_o [NI];
    logic [DW-1:0] rsp_inst_o  [NI];
    logic          rsp_fault_o [NI];
    logic          busy_o      [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 2 : 3);

        instmem_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

        assign bus_if.req_valid = req_valid[g];
        assign bus_if.req_addr  = req_addr[g];
        assign bus_if.rsp_ready = rsp_ready[g];
        assign bus_if.flush     = flush[g];
        assign req_ready_o[g]   = bus_if.req_ready;
        assign rsp_valid_o[g]   = bus_if.rsp_valid;
        assign rsp_inst_o[g]    = bus_if.rsp_inst;
        assign rsp_fault_o[g]   = bus_if.rsp_fault;

        instmem_fetch #(
            .DATA_W      (DW),
            .ADDR_W      (AW),
            .DEPTH       (24),
            .WAIT_STATES (WS),
            .NOP_WORD    (16'h0000)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .bus     (bus_if),
            .ld_en   (ld_en),
            .ld_addr (ld_addr),
            .ld_data (ld_data),
            .busy    (busy_o[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    // Single fetch with rsp_ready held high; checks latency, data, fault and
    // the return to idle.
    task automatic fetch(input int g, input logic [AW-1:0] a, input int exp_lat,
                         input logic [DW-1:0] exp_inst, input logic exp_fault,
                         input string tag);
        int n;
        rsp_ready[g] = 1'b1;
        req_valid[g] = 1'b1;
        req_addr[g]  = a;
        #1;
        check({tag, " req_ready"}, 32'(req_ready_o[g]), 32'd1);
        tick();
        req_valid[g] = 1'b0;
        n = 1;
        while (!rsp_valid_o[g] && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        check({tag, " inst"}, 32'(rsp_inst_o[g]), 32'(exp_inst));
        check({tag, " fault"}, 32'(rsp_fault_o[g]), 32'(exp_fault));
        tick();
        check({tag, " idle"}, 32'(busy_o[g]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic seen;
        rst     = 1'b1;
        ld_en   = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        for (int g = 0; g < NI; g++) begin
            req_valid[g] = 1'b0;
            req_addr[g]  = '0;
            rsp_ready[g] = 1'b0;
            flush[g]     = 1'b0;
        end
        tick();
        tick();

        // Reset state
        for (int g = 0; g < NI; g++) begin
            check($sformatf("rst rsp_valid[%0d]", g), 32'(rsp_valid_o[g]), 32'd0);
            check($sformatf("rst busy[%0d]", g), 32'(busy_o[g]), 32'd0);
            check($sformatf("rst rsp_inst[%0d]", g), 32'(rsp_inst_o[g]), 32'd0);
            check($sformatf("rst rsp_fault[%0d]", g), 32'(rsp_fault_o[g]), 32'd0);
        end
        check("rst req_ready", 32'(req_ready_o[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("idle req_ready", 32'(req_ready_o[0]), 32'd1);

        // Program load; req_ready must drop while ld_en is high
        ld_en   = 1'b1;
        ld_addr = 13'd0;
        ld_data = 16'h9901;
        #1;
        check("ld blocks req_ready", 32'(req_ready_o[0]), 32'd0);
        tick();
        ld_en = 1'b0;
        load(13'd1,  16'h9A02);
        load(13'd2,  16'h09C0);
        load(13'd5,  16'h5A5A);
        load(13'd30, 16'hFFFF);
        load(13'd24, 16'h1111);

        // Back-to-back fetch, WAIT_STATES=0
        rsp_ready[0] = 1'b1;
        req_valid[0] = 1'b1;
        req_addr[0]  = 13'd0;
        tick();
        req_addr[0] = 13'd1;
        #1;
        check("b2b rsp_valid0", 32'(rsp_valid_o[0]), 32'd1);
        check("b2b inst0", 32'(rsp_inst_o[0]), 32'h9901);
        check("b2b fault0", 32'(rsp_fault_o[0]), 32'd0);
        check("b2b req_ready", 32'(req_ready_o[0]), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        check("b2b rsp_valid1", 32'(rsp_valid_o[0]), 32'd1);
        check("b2b inst1", 32'(rsp_inst_o[0]), 32'h9A02);
        tick();
        check("b2b rsp_valid end", 32'(rsp_valid_o[0]), 32'd0);
        check("b2b busy end", 32'(busy_o[0]), 32'd0);

        // Range boundary and ignored out-of-range loads
        fetch(0, 13'd24,   1, 16'h0000, 1'b1, "oor 24");
        fetch(0, 13'd8191, 1, 16'h0000, 1'b1, "oor 8191");
        fetch(0, 13'd30,   1, 16'h0000, 1'b1, "oor load 30");
        fetch(0, 13'd23,   1, 16'h0000, 1'b0, "last word 23");

        // Response held stable under backpressure
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_addr[0]  = 13'd1;
        tick();
        req_valid[0] = 1'b0;
        check("hold req_ready", 32'(req_ready_o[0]), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold rsp_valid c%0d", i), 32'(rsp_valid_o[0]), 32'd1);
            check($sformatf("hold inst c%0d", i), 32'(rsp_inst_o[0]), 32'h9A02);
            tick();
        end
        rsp_ready[0] = 1'b1;
        tick();
        check("hold release rsp_valid", 32'(rsp_valid_o[0]), 32'd0);
        check("hold release busy", 32'(busy_o[0]), 32'd0);

        // WAIT_STATES=3 latency plus read-before-write on the read edge
        rsp_ready[2] = 1'b1;
        req_valid[2] = 1'b1;
        req_addr[2]  = 13'd2;
        tick();
        req_valid[2] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("ws3 rsp_valid c%0d", k), 32'(rsp_valid_o[2]), 32'd0);
            check($sformatf("ws3 req_ready c%0d", k), 32'(req_ready_o[2]), 32'd0);
            check($sformatf("ws3 busy c%0d", k), 32'(busy_o[2]), 32'd1);
            if (k == 3) begin
                ld_en   = 1'b1;
                ld_addr = 13'd2;
                ld_data = 16'hBEEF;
            end
            tick();
        end
        ld_en = 1'b0;
        check("ws3 rsp_valid c4", 32'(rsp_valid_o[2]), 32'd1);
        check("ws3 rbw old word", 32'(rsp_inst_o[2]), 32'h09C0);
        tick();
        fetch(2, 13'd2, 4, 16'hBEEF, 1'b0, "ws3 new word");

        // Flush one cycle after accept, WAIT_STATES=2
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b1;
        req_addr[1]  = 13'd1;
        tick();
        req_addr[1] = 13'd3;
        flush[1]    = 1'b1;
        #1;
        check("flush req_ready", 32'(req_ready_o[1]), 32'd0);
        tick();
        flush[1]     = 1'b0;
        req_valid[1] = 1'b0;
        check("flush busy", 32'(busy_o[1]), 32'd0);
        seen = rsp_valid_o[1];
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | rsp_valid_o[1];
        end
        check("flush no response", 32'(seen), 32'd0);
        fetch(1, 13'd5, 3, 16'h5A5A, 1'b0, "after flush");

        // Reset while in WAIT; array contents survive
        req_valid[2] = 1'b1;
        req_addr[2]  = 13'd0;
        tick();
        req_valid[2] = 1'b0;
        tick();
        check("pre-rst busy", 32'(busy_o[2]), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("wait rst rsp_valid", 32'(rsp_valid_o[2]), 32'd0);
        check("wait rst busy", 32'(busy_o[2]), 32'd0);
        check("wait rst rsp_inst", 32'(rsp_inst_o[2]), 32'd0);
        fetch(2, 13'd0, 4, 16'h9901, 1'b0, "post rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_instmem_fetch
`default_nettype wire

// File: doc/instmem_fetch.md
Name: instmem_fetch

Overview:
Parametrised instruction memory for the MIPS16 core with a valid/ready fetch handshake, configurable wait states, out-of-range fault reporting and a pipeline-redirect flush. A load port lets the bench or boot logic write the program into the array at run time. It sits between the PC/fetch stage and the decode stage, and replaces the fixed 24-word, 16-bit, single-cycle instruction store.

Parameters:
DATA_W, 16, instruction width in bits
ADDR_W, 13, width of fetch and load addresses
DEPTH, 24, number of implemented words (must be <= 2**ADDR_W)
WAIT_STATES, 0, extra cycles between request acceptance and response (0..15)
NOP_WORD, 0, word returned on fault and used as the elaboration-time fill (add $0,$0,$0)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  fetch request present
req_ready  out  1  request accepted this cycle when req_valid is also high
req_addr  in  ADDR_W  word address of the fetch
rsp_valid  out  1  response held on rsp_inst/rsp_fault
rsp_ready  in  1  consumer takes the response
rsp_inst  out  DATA_W  fetched instruction
rsp_fault  out  1  fetched address was >= DEPTH
flush  in  1  cancel any outstanding fetch (branch/jump redirect)
ld_en  in  1  write ld_data to ld_addr this cycle
ld_addr  in  ADDR_W  load word address
ld_data  in  DATA_W  load word
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; rsp_valid=0, rsp_inst=0, rsp_fault=0; wait counter=0; any pending request is dropped. Array contents are NOT cleared by rst.
- Array fill at elaboration: every word = NOP_WORD.
- FSM states:
  - IDLE: no request pending.
  - WAIT: wait counter running.
  - RESP: response held.
- req_ready = !rst && !flush && !ld_en && (state==IDLE || (state==RESP && rsp_ready)). This is combinational from the state and these inputs.
- Accept (req_valid && req_ready):
  - latch req_addr;
  - if WAIT_STATES==0, go to RESP on the next edge;
  - otherwise load counter=WAIT_STATES and go to WAIT.
- WAIT: the counter decrements each cycle. On the edge where the counter is 1, read the array and go to RESP.
- Latency: rsp_valid rises exactly WAIT_STATES+1 cycles after the accepting edge.
- Array read happens on the edge entering RESP, using the latched address.
  - If the latched address >= DEPTH (compare at full ADDR_W width): rsp_inst=NOP_WORD, rsp_fault=1.
  - Otherwise: rsp_inst=mem[addr], rsp_fault=0.
- RESP: rsp_valid=1. rsp_inst and rsp_fault are held stable while rsp_ready=0.
  - rsp_ready=1 with no new accept: go to IDLE; rsp_valid=0 next cycle.
  - rsp_ready=1 with a same-cycle accept: back-to-back fetch. With WAIT_STATES=0 this sustains one instruction per cycle and stays in RESP with new data.
- Flush: from any state, go to IDLE on the next edge. rsp_valid=0 the next cycle and the response is discarded. No request is accepted in the flush cycle. rsp_inst keeps its last value; only rsp_valid qualifies it.
- Load:
  - ld_en=1 with ld_addr < DEPTH writes on the edge.
  - ld_addr >= DEPTH: the write is ignored silently.
  - While ld_en=1, req_ready=0, so loads and fetch accepts never coincide.
  - A load to the address being read on the same edge: the read returns the OLD word (read-before-write).
  - Loads are legal in any state and do not disturb the FSM.
- Priority, highest first: rst, flush, FSM.
- busy = (state != IDLE). It is 0 in reset.

Decomposition:
- Package instmem_pkg:
  - state enum {S_IDLE, S_WAIT, S_RESP};
  - NOP_WORD default constant;
  - default DATA_W/ADDR_W/DEPTH constants;
  - WAIT_W = 4 counter width.
- Sub-module instmem_array: DEPTH x DATA_W storage with one synchronous write port, one synchronous read port with read-before-write, range check and fault output.
- instmem_fetch holds the FSM, counter, handshake and address latch.

Test Plan:
- Default params: load mem[0]=0x9901, mem[1]=0x9A02; fetch 0 then 1 back-to-back with rsp_ready=1 -> rsp_valid on consecutive cycles, rsp_inst 0x9901 then 0x9A02, rsp_fault=0.
- WAIT_STATES=3: fetch addr 2 holding 0x09C0 -> rsp_valid rises exactly 4 cycles after accept; req_ready=0 during WAIT.
- Fetch addr 24 and addr 8191 (DEPTH=24) -> rsp_inst=0x0000, rsp_fault=1; ld_addr=30, ld_data=0xFFFF, then fetch 30 -> still 0x0000 with fault.
- rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_inst stay stable; release -> IDLE next cycle.
- WAIT_STATES=2: flush one cycle after accept -> rsp_valid never asserts for that request; a new fetch of addr 5 after flush returns mem[5].
- rst asserted while in WAIT -> next cycle state=IDLE, rsp_valid=0, busy=0; previously loaded contents survive reset, so fetch 0 -> 0x9901.
